// File: rtl/hsv2rgb_pkg.sv
// Shared constants, sector encoding and payload types for the HSV -> RGB888 pipeline.
package hsv2rgb_pkg;

    localparam int unsigned H_W  = 9;
    localparam int unsigned S_W  = 9;
    localparam int unsigned V_W  = 8;
    localparam int unsigned F_W  = 6;
    localparam int unsigned VS_W = 17;
    localparam int unsigned X_W  = 23;
    localparam int unsigned LAT  = 5;

    localparam int unsigned H_DEG    = 360;
    localparam int unsigned SECT_DEG = 60;
    localparam int unsigned S_FULL   = 256;
    localparam int unsigned DIV_K    = 15360;

    typedef enum logic [2:0] {
        SECT_0 = 3'd0,
        SECT_1 = 3'd1,
        SECT_2 = 3'd2,
        SECT_3 = 3'd3,
        SECT_4 = 3'd4,
        SECT_5 = 3'd5
    } sector_e;

    typedef struct packed {
        logic [V_W-1:0] r;
        logic [V_W-1:0] g;
        logic [V_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } sync_t;

    // v - d, floored at zero
    function automatic logic [V_W-1:0] sub_clip(input logic [V_W-1:0] v, input logic [V_W:0] d);
        return (d > {1'b0, v}) ? '0 : V_W'({1'b0, v} - d);
    endfunction

endpackage

// File: rtl/hsv2rgb_if.sv
// HSV input stream and RGB output stream of the converter.
interface hsv2rgb_if;
    import hsv2rgb_pkg::*;

    logic           hsv_vs;
    logic           hsv_hs;
    logic           hsv_de;
    logic [H_W-1:0] hsv_h;
    logic [S_W-1:0] hsv_s;
    logic [V_W-1:0] hsv_v;

    logic           rgb_vs;
    logic           rgb_hs;
    logic           rgb_de;
    logic [V_W-1:0] rgb_r;
    logic [V_W-1:0] rgb_g;
    logic [V_W-1:0] rgb_b;

    modport master (
        output hsv_vs, hsv_hs, hsv_de, hsv_h, hsv_s, hsv_v,
        input  rgb_vs, rgb_hs, rgb_de, rgb_r, rgb_g, rgb_b
    );

    modport slave (
        input  hsv_vs, hsv_hs, hsv_de, hsv_h, hsv_s, hsv_v,
        output rgb_vs, rgb_hs, rgb_de, rgb_r, rgb_g, rgb_b
    );

endinterface

// File: rtl/hsv2rgb_sector_decode.sv
// Registered hue decode: wraps h>=360, then splits into 60-degree sector and offset.
module hsv2rgb_sector_decode
    import hsv2rgb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [H_W-1:0] h_i,
    output sector_e        sector_o,
    output logic [F_W-1:0] f_o
);

    logic [H_W-1:0] h_wrap;
    logic [H_W-1:0] base;
    sector_e        sector_d, sector_q;
    logic [F_W-1:0] f_d, f_q;

    always_comb begin
        h_wrap   = (h_i >= H_W'(H_DEG)) ? h_i - H_W'(H_DEG) : h_i;
        sector_d = SECT_0;
        base     = '0;
        if (h_wrap >= H_W'(5 * SECT_DEG)) begin
            sector_d = SECT_5;
            base     = H_W'(5 * SECT_DEG);
        end else if (h_wrap >= H_W'(4 * SECT_DEG)) begin
            sector_d = SECT_4;
            base     = H_W'(4 * SECT_DEG);
        end else if (h_wrap >= H_W'(3 * SECT_DEG)) begin
            sector_d = SECT_3;
            base     = H_W'(3 * SECT_DEG);
        end else if (h_wrap >= H_W'(2 * SECT_DEG)) begin
            sector_d = SECT_2;
            base     = H_W'(2 * SECT_DEG);
        end else if (h_wrap >= H_W'(SECT_DEG)) begin
            sector_d = SECT_1;
            base     = H_W'(SECT_DEG);
        end
        f_d = F_W'(h_wrap - base);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sector_q <= SECT_0;
            f_q      <= '0;
        end else begin
            sector_q <= sector_d;
            f_q      <= f_d;
        end
    end

    assign sector_o = sector_q;
    assign f_o      = f_q;

endmodule

// File: rtl/hsv2rgb.sv
// Five-stage HSV -> RGB888 pipeline; syncs travel a matching delay line.
module hsv2rgb
    import hsv2rgb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    hsv2rgb_if.slave bus
);

    localparam int unsigned D_W = V_W + 1;

    // S1
    sector_e           sector1;
    logic [F_W-1:0]    f1;
    logic [V_W-1:0]    v1_d, v1_q;
    logic [S_W-1:0]    s1_d, s1_q;
    // S2
    sector_e           sector2_q;
    logic [F_W-1:0]    f2_q;
    logic [V_W-1:0]    v2_q;
    logic [VS_W-1:0]   vs2_d, vs2_q;
    // S3
    sector_e           sector3_q;
    logic [V_W-1:0]    v3_q, p3_d, p3_q;
    logic [X_W-1:0]    xq3_d, xq3_q, xt3_d, xt3_q;
    // S4
    sector_e           sector4_q;
    logic [V_W-1:0]    v4_q, p4_q, q4_d, q4_q, t4_d, t4_q;
    // S5 and sync line
    rgb_t              rgb_d, rgb_q;
    sync_t [LAT-1:0]   sync_d, sync_q;

    hsv2rgb_sector_decode u_dec (
        .clk      (clk),
        .reset    (reset),
        .h_i      (bus.hsv_h),
        .sector_o (sector1),
        .f_o      (f1)
    );

    always_comb begin
        s1_d  = (bus.hsv_s > S_W'(S_FULL)) ? S_W'(S_FULL) : bus.hsv_s;
        v1_d  = bus.hsv_v;
        vs2_d = VS_W'(v1_q) * VS_W'(s1_q);
        p3_d  = sub_clip(v2_q, D_W'(vs2_q >> 8));
        xq3_d = X_W'(vs2_q) * X_W'(f2_q);
        xt3_d = X_W'(vs2_q) * X_W'(F_W'(SECT_DEG) - f2_q);
        // divide by 256*60 gives v*s*frac scaled back to the 8-bit value range
        q4_d  = sub_clip(v3_q, D_W'(xq3_q / X_W'(DIV_K)));
        t4_d  = sub_clip(v3_q, D_W'(xt3_q / X_W'(DIV_K)));

        rgb_d = '0;
        case (sector4_q)
            SECT_0:  rgb_d = '{r: v4_q, g: t4_q, b: p4_q};
            SECT_1:  rgb_d = '{r: q4_q, g: v4_q, b: p4_q};
            SECT_2:  rgb_d = '{r: p4_q, g: v4_q, b: t4_q};
            SECT_3:  rgb_d = '{r: p4_q, g: q4_q, b: v4_q};
            SECT_4:  rgb_d = '{r: t4_q, g: p4_q, b: v4_q};
            SECT_5:  rgb_d = '{r: v4_q, g: p4_q, b: q4_q};
            default: rgb_d = '0;
        endcase

        sync_d = {sync_q[LAT-2:0], sync_t'({bus.hsv_vs, bus.hsv_hs, bus.hsv_de})};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q      <= '0;
            s1_q      <= '0;
            sector2_q <= SECT_0;
            f2_q      <= '0;
            v2_q      <= '0;
            vs2_q     <= '0;
            sector3_q <= SECT_0;
            v3_q      <= '0;
            p3_q      <= '0;
            xq3_q     <= '0;
            xt3_q     <= '0;
            sector4_q <= SECT_0;
            v4_q      <= '0;
            p4_q      <= '0;
            q4_q      <= '0;
            t4_q      <= '0;
            rgb_q     <= '0;
            sync_q    <= '0;
        end else begin
            v1_q      <= v1_d;
            s1_q      <= s1_d;
            sector2_q <= sector1;
            f2_q      <= f1;
            v2_q      <= v1_q;
            vs2_q     <= vs2_d;
            sector3_q <= sector2_q;
            v3_q      <= v2_q;
            p3_q      <= p3_d;
            xq3_q     <= xq3_d;
            xt3_q     <= xt3_d;
            sector4_q <= sector3_q;
            v4_q      <= v3_q;
            p4_q      <= p3_q;
            q4_q      <= q4_d;
            t4_q      <= t4_d;
            rgb_q     <= rgb_d;
            sync_q    <= sync_d;
        end
    end

    assign bus.rgb_r  = rgb_q.r;
    assign bus.rgb_g  = rgb_q.g;
    assign bus.rgb_b  = rgb_q.b;
    assign bus.rgb_vs = sync_q[LAT-1].vs;
    assign bus.rgb_hs = sync_q[LAT-1].hs;
    assign bus.rgb_de = sync_q[LAT-1].de;

endmodule

// File: tb/tb_hsv2rgb.sv
// Scoreboard bench for hsv2rgb: driver queues expected pixels, negedge monitor retires them.
module tb_hsv2rgb;

    localparam int PIPE = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hsv2rgb_if bus ();

    hsv2rgb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         due;
        int         id;
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int clip8(input int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    // Reference: standard sector/fraction HSV formula in plain integer arithmetic
    function automatic void ref_px(input int h, input int s, input int v,
                                   output int r, output int g, output int b);
        int hh, ss, sec, f, vs, p, q, t;
        hh  = (h >= 360) ? h - 360 : h;
        ss  = (s > 256) ? 256 : s;
        sec = hh / 60;
        f   = hh % 60;
        vs  = v * ss;
        p   = clip8(v - vs / 256);
        q   = clip8(v - (vs * f) / 15360);
        t   = clip8(v - (vs * (60 - f)) / 15360);
        case (sec)
            0:       begin r = v; g = t; b = p; end
            1:       begin r = q; g = v; b = p; end
            2:       begin r = p; g = v; b = t; end
            3:       begin r = p; g = q; b = v; end
            4:       begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
    endfunction

    task automatic push_exp(input int due, input int id, input logic vs, input logic hs,
                            input logic de, input int r, input int g, input int b);
        exp_t e;
        e.due = due; e.id = id; e.vs = vs; e.hs = hs; e.de = de;
        e.r = 8'(r); e.g = 8'(g); e.b = 8'(b);
        sbq.push_back(e);
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de,
                         input int h, input int s, input int v,
                         input int r, input int g, input int b,
                         input bit push, input int id);
        @(posedge clk);
        #1;
        bus.hsv_vs = vs;
        bus.hsv_hs = hs;
        bus.hsv_de = de;
        bus.hsv_h  = 9'(h);
        bus.hsv_s  = 9'(s);
        bus.hsv_v  = 8'(v);
        if (push) push_exp(cyc + PIPE, id, vs, hs, de, r, g, b);
    endtask

    task automatic drive_rand(input bit push, input int id);
        int h, s, v, r, g, b;
        logic vs, hs, de;
        h  = $urandom_range(0, 511);
        s  = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 262) : $urandom_range(0, 511);
        v  = $urandom_range(0, 255);
        vs = ($urandom_range(0, 15) == 0);
        hs = ($urandom_range(0, 3) == 0);
        de = ($urandom_range(0, 3) != 0);
        ref_px(h, s, v, r, g, b);
        drive(vs, hs, de, h, s, v, r, g, b, push, id);
    endtask

    // Pipeline holds zeros for PIPE-1 cycles after release, then the idle pixel
    task automatic release_rst();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k < PIPE; k++) push_exp(cyc + k, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        bus.hsv_vs = 1'b0; bus.hsv_hs = 1'b0; bus.hsv_de = 1'b0;
        bus.hsv_h = '0; bus.hsv_s = '0; bus.hsv_v = '0;
        push_exp(cyc + PIPE, -2, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    function automatic bit outs_zero();
        return bus.rgb_vs == 1'b0 && bus.rgb_hs == 1'b0 && bus.rgb_de == 1'b0 &&
               bus.rgb_r == 8'd0 && bus.rgb_g == 8'd0 && bus.rgb_b == 8'd0;
    endfunction

    // Monitor: reset forces zeros; otherwise retire the entry due this cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            n_cmp++;
            if (!outs_zero()) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got de=%0b r=%0d g=%0d b=%0d required all zero",
                         cyc, bus.rgb_de, bus.rgb_r, bus.rgb_g, bus.rgb_b);
            end
        end else if (sbq.size() > 0) begin
            if (sbq[0].due < cyc) begin
                e = sbq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_slot id=%0d due=%0d now=%0d", e.id, e.due, cyc);
            end else if (sbq[0].due == cyc) begin
                e = sbq.pop_front();
                n_cmp++;
                if (bus.rgb_vs !== e.vs || bus.rgb_hs !== e.hs || bus.rgb_de !== e.de ||
                    bus.rgb_r !== e.r || bus.rgb_g !== e.g || bus.rgb_b !== e.b) begin
                    n_bad++;
                    $display("FAIL pixel id=%0d cyc=%0d got vs/hs/de=%0b%0b%0b rgb=(%0d,%0d,%0d) required vs/hs/de=%0b%0b%0b rgb=(%0d,%0d,%0d)",
                             e.id, cyc, bus.rgb_vs, bus.rgb_hs, bus.rgb_de,
                             bus.rgb_r, bus.rgb_g, bus.rgb_b,
                             e.vs, e.hs, e.de, e.r, e.g, e.b);
                end
            end
        end
    end

    int dir_h[12] = '{0,   120, 240, 30,  300, 400, 0,   30,  40,  200, 359, 180};
    int dir_s[12] = '{256, 256, 256, 256, 256, 256, 300, 511, 256, 0,   256, 256};
    int dir_v[12] = '{255, 255, 255, 200, 255, 255, 255, 200, 255, 77,  0,   255};
    int dir_r[12] = '{255, 0,   0,   200, 255, 255, 255, 200, 255, 77,  0,   0};
    int dir_g[12] = '{0,   255, 0,   100, 0,   170, 0,   100, 170, 77,  0,   255};
    int dir_b[12] = '{0,   0,   255, 0,   255, 0,   0,   0,   0,   77,  0,   255};

    initial begin : stim
        bus.hsv_vs = 1'b0; bus.hsv_hs = 1'b0; bus.hsv_de = 1'b0;
        bus.hsv_h = '0; bus.hsv_s = '0; bus.hsv_v = '0;
        repeat (3) @(posedge clk);
        release_rst();

        for (int i = 0; i < 12; i++)
            drive(1'b0, 1'b0, 1'b1, dir_h[i], dir_s[i], dir_v[i],
                  dir_r[i], dir_g[i], dir_b[i], 1'b1, 100 + i);

        for (int h = 0; h < 360; h++)
            drive(1'b0, h[0], 1'b1, h, 0, 77, 77, 77, 77, 1'b1, 1000 + h);

        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'b0, 1'b1, $urandom_range(0, 511), $urandom_range(0, 511), 0,
                  0, 0, 0, 1'b1, 2000 + i);

        for (int i = 0; i < 1500; i++) drive_rand(1'b1, 3000 + i);

        // Async reset in the middle of an active line
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 60, 256, 200, 0, 0, 0, 1'b0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        sbq.delete();
        #1;
        n_cmp++;
        if (!outs_zero()) begin
            n_bad++;
            $display("FAIL async_reset got de=%0b r=%0d g=%0d b=%0d required all zero",
                     bus.rgb_de, bus.rgb_r, bus.rgb_g, bus.rgb_b);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 60, 256, 200, 0, 0, 0, 1'b0, 0);
        release_rst();

        for (int i = 0; i < 300; i++) drive_rand(1'b1, 5000 + i);

        repeat (PIPE + 3) @(posedge clk);
        #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_bad++;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
